// File: rtl/xlr8_pm_arb.sv
// Two-port program-memory arbiter: alternating-priority grant, one registered
// memory-port stage, and read responses routed back two cycles after the grant.
module xlr8_pm_arb #(
    parameter int PM_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst_flash,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_wr,
    input  logic        b_wr,
    input  logic [16:0] a_addr,
    input  logic [16:0] b_addr,
    input  logic [15:0] a_wdata,
    input  logic [15:0] b_wdata,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [15:0] a_rdata,
    output logic [15:0] b_rdata,
    output logic        pm_ce,
    output logic        pm_wr,
    output logic [16:0] pm_addr,
    output logic [15:0] pm_wr_data,
    input  logic [15:0] pm_rd_data,
    output logic        err_oor
);

    // 18 bits so that PM_SIZE=128 (2^17 words) still fits the bound.
    localparam logic [17:0] PM_WORDS = 18'(PM_SIZE * 1024);
    localparam logic        PORT_A   = 1'b0;
    localparam logic        PORT_B   = 1'b1;

    logic        r_last_gnt;
    logic        r_pm_ce;
    logic        r_pm_wr;
    logic [16:0] r_pm_addr;
    logic [15:0] r_pm_wdata;
    logic        r_err;
    logic        r_s1_rd;
    logic        r_s1_port;
    logic        r_s1_inr;
    logic        r_s2_rd;
    logic        r_s2_port;
    logic        r_s2_inr;

    logic        w_a_gnt;
    logic        w_b_gnt;
    logic        w_acc;
    logic        w_wr;
    logic [16:0] w_addr;
    logic [15:0] w_wdata;
    logic        w_inr;
    logic        w_rv;
    logic [15:0] w_rdata;

    // Under contention the port that did not win last time is served.
    assign w_a_gnt = !rst_flash && a_req && (!b_req || r_last_gnt == PORT_B);
    assign w_b_gnt = !rst_flash && b_req && (!a_req || r_last_gnt == PORT_A);
    assign w_acc   = w_a_gnt || w_b_gnt;
    assign w_wr    = w_b_gnt ? b_wr    : a_wr;
    assign w_addr  = w_b_gnt ? b_addr  : a_addr;
    assign w_wdata = w_b_gnt ? b_wdata : a_wdata;
    assign w_inr   = ({1'b0, w_addr} < PM_WORDS);

    always_ff @(posedge clk) begin
        if (rst_flash) begin
            r_last_gnt <= PORT_B;
            r_pm_ce    <= 1'b0;
            r_pm_wr    <= 1'b0;
            r_pm_addr  <= '0;
            r_pm_wdata <= '0;
            r_err      <= 1'b0;
            r_s1_rd    <= 1'b0;
            r_s1_port  <= PORT_A;
            r_s1_inr   <= 1'b0;
            r_s2_rd    <= 1'b0;
            r_s2_port  <= PORT_A;
            r_s2_inr   <= 1'b0;
        end else begin
            r_pm_ce   <= w_acc && w_inr;
            r_pm_wr   <= w_acc && w_inr && w_wr;
            r_err     <= w_acc && !w_inr;
            r_s1_rd   <= w_acc && !w_wr;
            r_s1_port <= w_b_gnt ? PORT_B : PORT_A;
            r_s1_inr  <= w_inr;
            if (w_acc) begin
                r_last_gnt <= w_b_gnt ? PORT_B : PORT_A;
                r_pm_addr  <= w_addr;
                r_pm_wdata <= w_wdata;
            end
            r_s2_rd   <= r_s1_rd;
            r_s2_port <= r_s1_port;
            r_s2_inr  <= r_s1_inr;
        end
    end

    // Responses still in flight when reset arrives are suppressed immediately.
    assign w_rv    = r_s2_rd && !rst_flash;
    assign w_rdata = (w_rv && r_s2_inr) ? pm_rd_data : 16'h0000;

    assign a_gnt      = w_a_gnt;
    assign b_gnt      = w_b_gnt;
    assign a_rvalid   = w_rv && (r_s2_port == PORT_A);
    assign b_rvalid   = w_rv && (r_s2_port == PORT_B);
    assign a_rdata    = a_rvalid ? w_rdata : 16'h0000;
    assign b_rdata    = b_rvalid ? w_rdata : 16'h0000;
    assign pm_ce      = r_pm_ce;
    assign pm_wr      = r_pm_wr;
    assign pm_addr    = r_pm_addr;
    assign pm_wr_data = r_pm_wdata;
    assign err_oor    = r_err && !rst_flash;

endmodule

// File: tb/tb_xlr8_pm_arb.sv
// Bench for xlr8_pm_arb: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model and a memory shadow.
module tb_xlr8_pm_arb;

    localparam int PM_SIZE  = 16;
    localparam int PM_WORDS = PM_SIZE * 1024;

    logic        clk = 1'b0;
    logic        rst_flash = 1'b1;
    logic        a_req = 1'b0, b_req = 1'b0, a_wr = 1'b0, b_wr = 1'b0;
    logic [16:0] a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        pm_ce, pm_wr, err_oor;
    logic [16:0] pm_addr;
    logic [15:0] pm_wr_data;
    logic [15:0] pm_rd_data = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    xlr8_pm_arb #(.PM_SIZE(PM_SIZE)) dut (
        .clk(clk), .rst_flash(rst_flash),
        .a_req(a_req), .b_req(b_req), .a_wr(a_wr), .b_wr(b_wr),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .pm_ce(pm_ce), .pm_wr(pm_wr), .pm_addr(pm_addr), .pm_wr_data(pm_wr_data),
        .pm_rd_data(pm_rd_data), .err_oor(err_oor)
    );

    always #5 clk = ~clk;

    // Program memory: one-cycle read latency, garbage when not reading.
    logic [15:0] mem    [0:PM_WORDS-1];
    logic [15:0] shadow [0:PM_WORDS-1];

    initial begin
        for (int i = 0; i < PM_WORDS; i++) begin
            mem[i]    = 16'(i * 37 + 5);
            shadow[i] = 16'(i * 37 + 5);
        end
        mem[16]    = 16'hBEEF;
        shadow[16] = 16'hBEEF;
    end

    always @(posedge clk) begin
        if (pm_ce && pm_wr) mem[pm_addr[13:0]] <= pm_wr_data;
        if (pm_ce && !pm_wr) pm_rd_data <= mem[pm_addr[13:0]];
        else pm_rd_data <= 16'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one record per cycle describing what was accepted.
    typedef struct packed {
        logic        v;
        logic        port;
        logic        wr;
        logic        inr;
        logic [15:0] rd;
        logic        rst;
    } rec_t;

    rec_t        h1 = '0, h2 = '0;
    logic        m_last = 1'b1;
    logic [16:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic        last_ga = 1'b0, last_gb = 1'b0;

    always @(negedge clk) begin
        logic        ga, gb, ce, rva, rvb, use_b;
        logic [16:0] addr;
        rec_t        cur;
        cyc++;
        ga = 1'b0;
        gb = 1'b0;
        if (!rst_flash) begin
            if (a_req && b_req) begin
                if (m_last) ga = 1'b1; else gb = 1'b1;
            end else begin
                ga = a_req;
                gb = b_req;
            end
        end
        ce  = h1.v && h1.inr;
        rva = h2.v && !h2.wr && !h2.port && !h1.rst && !rst_flash;
        rvb = h2.v && !h2.wr &&  h2.port && !h1.rst && !rst_flash;
        chk("a_gnt", a_gnt, ga);
        chk("b_gnt", b_gnt, gb);
        chk("pm_ce", pm_ce, ce);
        chk("pm_wr", pm_wr, ce && h1.wr);
        chk("pm_addr", pm_addr, m_addr);
        chk("pm_wr_data", pm_wr_data, m_wdata);
        chk("err_oor", err_oor, h1.v && !h1.inr && !rst_flash);
        chk("a_rvalid", a_rvalid, rva);
        chk("b_rvalid", b_rvalid, rvb);
        chk("a_rdata", a_rdata, (rva && h2.inr) ? h2.rd : 16'h0);
        chk("b_rdata", b_rdata, (rvb && h2.inr) ? h2.rd : 16'h0);

        use_b    = gb;
        addr     = use_b ? b_addr : a_addr;
        cur      = '0;
        cur.v    = ga || gb;
        cur.port = use_b;
        cur.wr   = use_b ? b_wr : a_wr;
        cur.inr  = (int'(addr) < PM_WORDS);
        cur.rst  = rst_flash;
        if (cur.v && cur.inr) begin
            if (cur.wr) shadow[addr[13:0]] = use_b ? b_wdata : a_wdata;
            else cur.rd = shadow[addr[13:0]];
        end
        if (rst_flash) begin
            m_last  = 1'b1;
            m_addr  = '0;
            m_wdata = '0;
        end else if (cur.v) begin
            m_last  = use_b;
            m_addr  = addr;
            m_wdata = use_b ? b_wdata : a_wdata;
        end
        h2 = h1;
        h1 = cur;
        last_ga = ga;
        last_gb = gb;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 17'h03FFF;
            1:       return 17'h04000;
            2:       return 17'h1FFFF;
            3, 4:    return 17'($urandom_range(0, 63));
            5:       return 17'($urandom_range(0, PM_WORDS - 1));
            6:       return 17'($urandom);
            default: return 17'h00000;
        endcase
    endfunction

    initial begin
        repeat (3) step();
        rst_flash = 1'b0;

        // Single read of 0x10 from A.
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin a_req = 1; a_wr = 0; a_addr = 17'h00010; end
            else a_req = 0;
            @(negedge clk);
            if (i == 0) chk("t1_a_gnt", a_gnt, 1);
            if (i == 1) begin
                chk("t1_pm_ce", pm_ce, 1);
                chk("t1_pm_wr", pm_wr, 0);
                chk("t1_pm_addr", pm_addr, 17'h00010);
            end
            if (i == 2) begin
                chk("t1_a_rvalid", a_rvalid, 1);
                chk("t1_a_rdata", a_rdata, 16'hBEEF);
                chk("t1_b_rvalid", b_rvalid, 0);
            end
            step();
        end

        // Contention right after reset: A,B,A,B.
        rst_flash = 1;
        step();
        rst_flash = 0;
        for (int i = 0; i < 6; i++) begin
            a_req = (i < 4); b_req = (i < 4);
            a_wr = 0; b_wr = 0;
            a_addr = 17'(i); b_addr = 17'(i + 8);
            @(negedge clk);
            chk("t2_a_gnt", a_gnt, (i < 4) && (i % 2 == 0));
            chk("t2_b_gnt", b_gnt, (i < 4) && (i % 2 == 1));
            chk("t2_a_rvalid", a_rvalid, (i >= 2) && (i % 2 == 0));
            chk("t2_b_rvalid", b_rvalid, (i >= 2) && (i % 2 == 1));
            step();
        end

        // B writes then reads back the top in-range word.
        for (int i = 0; i < 5; i++) begin
            b_req = (i < 2); b_wr = (i == 0); b_addr = 17'h03FFF; b_wdata = 16'h1234;
            @(negedge clk);
            if (i == 1) begin
                chk("t3_pm_wr1", pm_wr, 1);
                chk("t3_pm_wdata", pm_wr_data, 16'h1234);
            end
            if (i == 2) begin
                chk("t3_pm_wr2", pm_wr, 0);
                chk("t3_pm_ce2", pm_ce, 1);
            end
            chk("t3_b_rvalid", b_rvalid, i == 3);
            if (i == 3) chk("t3_b_rdata", b_rdata, 16'h1234);
            step();
        end

        // Out-of-range read then out-of-range write.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                a_req = (i == 0); a_wr = (k == 1);
                a_addr = (k == 0) ? 17'h04000 : 17'h1FFFF;
                @(negedge clk);
                if (i == 0) chk("t4_a_gnt", a_gnt, 1);
                if (i == 1) begin
                    chk("t4_pm_ce", pm_ce, 0);
                    chk("t4_err1", err_oor, 1);
                end
                if (i == 2) begin
                    chk("t4_err2", err_oor, 0);
                    chk("t4_a_rvalid", a_rvalid, k == 0);
                    chk("t4_a_rdata", a_rdata, 16'h0000);
                end
                step();
            end
        end

        // Reset while a read is in flight, then contention goes to A.
        for (int i = 0; i < 5; i++) begin
            rst_flash = (i == 1);
            a_req = (i == 0 || i == 2); b_req = (i == 2 || i == 3);
            a_wr = 0; b_wr = 0; a_addr = 17'h00010; b_addr = 17'h00020;
            @(negedge clk);
            if (i == 0) chk("t5_a_gnt0", a_gnt, 1);
            if (i == 2) begin
                chk("t5_a_rvalid", a_rvalid, 0);
                chk("t5_a_gnt2", a_gnt, 1);
                chk("t5_b_gnt2", b_gnt, 0);
            end
            if (i == 3) chk("t5_b_gnt3", b_gnt, 1);
            step();
        end
        b_req = 0;

        // Random traffic: requests held until granted, occasional reset.
        for (int n = 0; n < 3000; n++) begin
            rst_flash = ($urandom_range(0, 149) == 0);
            if (!a_req || last_ga) begin
                a_req = ($urandom_range(0, 3) != 0);
                a_wr = 1'($urandom_range(0, 1));
                a_addr = pick_addr();
                a_wdata = 16'($urandom);
            end
            if (!b_req || last_gb) begin
                b_req = ($urandom_range(0, 3) != 0);
                b_wr = 1'($urandom_range(0, 1));
                b_addr = pick_addr();
                b_wdata = 16'($urandom);
            end
            step();
        end
        rst_flash = 0; a_req = 0; b_req = 0;
        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
